// File: rtl/tx_retrans_ctrl_if.sv
// tx_retrans_ctrl_if: frame launch/result handshake between tx queue/PHY and the retransmit controller
interface tx_retrans_ctrl_if;
  logic tx_req;
  logic tx_need_ack;
  logic tx_allowed;
  logic tx_done;
  logic tx_start;
  logic tx_retry_flag;
  logic result_valid;
  logic result_ok;
  modport master (
    output tx_req, tx_need_ack, tx_allowed, tx_done,
    input  tx_start, tx_retry_flag, result_valid, result_ok
  );
  modport slave (
    input  tx_req, tx_need_ack, tx_allowed, tx_done,
    output tx_start, tx_retry_flag, result_valid, result_ok
  );
endinterface

// File: rtl/tx_retrans_ctrl.sv
// tx_retrans_ctrl: launches frames, waits for ACK, retries with CW doubling, reports outcome
module tx_retrans_ctrl #(
  parameter int MAX_RETRY_DEFAULT = 7,
  parameter int RX_WATCHDOG_US    = 300
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tsf_pulse_1M,
  tx_retrans_ctrl_if.slave     bus,
  input  logic                 pkt_header_valid_strobe,
  input  logic                 pkt_header_valid,
  input  logic                 fcs_in_strobe,
  input  logic                 fcs_valid,
  input  logic                 FC_DI_valid,
  input  logic [1:0]           FC_type,
  input  logic [3:0]           FC_subtype,
  input  logic                 addr1_valid,
  input  logic [47:0]          addr1,
  input  logic [47:0]          self_mac_addr,
  input  logic [6:0]           sifs_time,
  input  logic [4:0]           slot_time,
  input  logic [6:0]           phy_rx_start_delay_time,
  input  logic [3:0]           cw_min,
  input  logic [3:0]           cw_max,
  input  logic [3:0]           max_retry,
  output logic [3:0]           cw_exp,
  output logic [3:0]           retry_count,
  output logic [2:0]           state_dbg
);
  typedef enum logic [2:0] {IDLE, WAIT_GRANT, TX_BUSY, WAIT_ACK, RX_ACK, REPORT} state_t;
  state_t state_q, state_d;
  logic tx_start_q, tx_start_d, retry_flag_q, retry_flag_d;
  logic result_valid_q, result_valid_d, result_ok_q, result_ok_d;
  logic need_ack_q, need_ack_d, is_ack_q, is_ack_d, ra_ok_q, ra_ok_d;
  logic [9:0] ack_cnt_q, ack_cnt_d, wd_cnt_q, wd_cnt_d;
  logic [3:0] retry_q, retry_d, cw_q, cw_d, cw_top, cw_inc;
  logic [4:0] limit, cw_p1;
  logic [9:0] ack_top;
  logic fail;
  assign limit   = max_retry == 4'd0 ? 5'(MAX_RETRY_DEFAULT) : {1'b0, max_retry};
  assign ack_top = 10'(sifs_time) + 10'(slot_time) + 10'(phy_rx_start_delay_time);
  assign cw_top  = cw_max >= cw_min ? cw_max : cw_min;
  assign cw_p1   = {1'b0, cw_q} + 5'd1;
  assign cw_inc  = cw_p1 > {1'b0, cw_top} ? cw_top : cw_p1[3:0];
  // next-state, counters and registered outputs; a failed attempt is resolved in the same cycle
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    need_ack_d = need_ack_q;
    ack_cnt_d  = ack_cnt_q;
    wd_cnt_d   = wd_cnt_q;
    is_ack_d   = is_ack_q;
    ra_ok_d    = ra_ok_q;
    retry_d    = retry_q;
    cw_d       = cw_q;
    result_ok_d = 1'b0;
    fail       = 1'b0;
    case (state_q)
      IDLE: state_d = bus.tx_req ? WAIT_GRANT : IDLE;
      WAIT_GRANT: begin
        if (!bus.tx_req) state_d = IDLE;
        else if (bus.tx_allowed) begin
          tx_start_d = 1'b1;
          need_ack_d = bus.tx_need_ack;
          state_d    = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (bus.tx_done) begin
          ack_cnt_d   = '0;
          state_d     = need_ack_q ? WAIT_ACK : REPORT;
          result_ok_d = !need_ack_q;
        end
      end
      WAIT_ACK: begin
        ack_cnt_d = ack_cnt_q + {9'd0, tsf_pulse_1M};
        if (pkt_header_valid_strobe && pkt_header_valid) begin
          state_d  = RX_ACK;
          is_ack_d = 1'b0;
          ra_ok_d  = 1'b0;
          wd_cnt_d = '0;
        end else if (ack_cnt_q > ack_top) fail = 1'b1;
      end
      RX_ACK: begin
        wd_cnt_d = wd_cnt_q + {9'd0, tsf_pulse_1M};
        if (FC_DI_valid) is_ack_d = FC_type == 2'b01 && FC_subtype == 4'b1101;
        if (addr1_valid) ra_ok_d = addr1 == self_mac_addr;
        if (fcs_in_strobe) begin
          if (fcs_valid && is_ack_q && ra_ok_q) begin
            state_d     = REPORT;
            result_ok_d = 1'b1;
          end else fail = 1'b1;
        end else if (pkt_header_valid_strobe || wd_cnt_q > 10'(RX_WATCHDOG_US)) fail = 1'b1;
      end
      REPORT: begin
        retry_d = '0;
        cw_d    = cw_min;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fail) begin
      if ({1'b0, retry_q} + 5'd1 > limit) state_d = REPORT;
      else begin
        retry_d = retry_q + 4'd1;
        cw_d    = cw_inc;
        state_d = WAIT_GRANT;
      end
    end
    result_valid_d = state_d == REPORT;
    retry_flag_d   = retry_d != 4'd0;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      tx_start_q     <= 1'b0;
      retry_flag_q   <= 1'b0;
      result_valid_q <= 1'b0;
      result_ok_q    <= 1'b0;
      need_ack_q     <= 1'b0;
      is_ack_q       <= 1'b0;
      ra_ok_q        <= 1'b0;
      ack_cnt_q      <= '0;
      wd_cnt_q       <= '0;
      retry_q        <= '0;
      cw_q           <= cw_min;
    end else begin
      state_q        <= state_d;
      tx_start_q     <= tx_start_d;
      retry_flag_q   <= retry_flag_d;
      result_valid_q <= result_valid_d;
      result_ok_q    <= result_ok_d;
      need_ack_q     <= need_ack_d;
      is_ack_q       <= is_ack_d;
      ra_ok_q        <= ra_ok_d;
      ack_cnt_q      <= ack_cnt_d;
      wd_cnt_q       <= wd_cnt_d;
      retry_q        <= retry_d;
      cw_q           <= cw_d;
    end
  end
  assign bus.tx_start      = tx_start_q;
  assign bus.tx_retry_flag = retry_flag_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.result_ok     = result_ok_q;
  assign cw_exp            = cw_q;
  assign retry_count       = retry_q;
  assign state_dbg         = state_q;
endmodule
